// File: rtl/decommutor0.sv
// Output-side lane de-commutator for the 8-lane NTT/INTT pipeline tail.
// Undoes the per-group lane reflection and buffers beats in a 2-entry FIFO.
module decommutor0 #(
  parameter int LANES     = 8,
  parameter int DW        = 16,
  parameter int GROUP_LEN = 8,
  parameter int GROUPS    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       nttend,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DW-1:0]        lane_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*DW-1:0]        lane_out,
  output logic [$clog2(GROUPS)-1:0]  group_idx,
  output logic                       frame_done
);

  localparam int W  = LANES * DW;
  localparam int CW = $clog2(GROUP_LEN * GROUPS);
  localparam int SW = $clog2(GROUP_LEN);
  localparam int GW = $clog2(GROUPS);
  localparam logic [CW-1:0] LAST = CW'(GROUP_LEN * GROUPS - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e          occ_q, occ_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic [W-1:0]  tail_q, tail_d;
  logic          fd_q, fd_d;
  logic [W-1:0]  mapped;
  logic [GW-1:0] grp;
  logic          push;
  logic          pop;

  assign grp        = beat_cnt_q[CW-1:SW];
  assign in_ready   = (occ_q != FULL);
  assign out_valid  = (occ_q != EMPTY);
  assign lane_out   = head_q;
  assign group_idx  = grp;
  assign frame_done = fd_q;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  // Group k reflects lanes inside the window i+j == k; the rest pass.
  always_comb begin
    mapped = lane_in;
    for (int i = 0; i < LANES; i++) begin
      if (int'(grp) >= i && int'(grp) - i < LANES)
        mapped[i*DW +: DW] = lane_in[(int'(grp) - i)*DW +: DW];
    end
  end

  always_comb begin
    occ_d      = occ_q;
    beat_cnt_d = beat_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fd_d       = 1'b0;
    if (nttend) begin
      occ_d      = EMPTY;
      beat_cnt_d = '0;
    end else begin
      if (push) beat_cnt_d = beat_cnt_q + 1'b1;
      fd_d = push && (beat_cnt_q == LAST);
      unique case (occ_q)
        EMPTY: begin
          if (push) begin
            head_d = mapped;
            occ_d  = ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            push && pop: head_d = mapped;
            push && !pop: begin
              tail_d = mapped;
              occ_d  = FULL;
            end
            !push && pop: occ_d = EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            head_d = tail_q;
            occ_d  = ONE;
          end
        end
        default: occ_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= EMPTY;
      beat_cnt_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fd_q       <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      beat_cnt_q <= beat_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fd_q       <= fd_d;
    end
  end

endmodule

// File: tb/tb_decommutor0.sv
// Bench for decommutor0: queue-based reference model plus directed
// and randomized traffic covering mapping, backpressure, flush and reset.
module tb_decommutor0;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         nttend = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] lane_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] lane_out;
  logic [3:0]   group_idx;
  logic         frame_done;

  decommutor0 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nttend     (nttend),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .lane_in    (lane_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .lane_out   (lane_out),
    .group_idx  (group_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] nat(input int b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(64*i + b);
    return r;
  endfunction

  // Spec rule: out lane i takes in lane k-i when that lane exists.
  function automatic logic [W-1:0] decom(input logic [W-1:0] d, input int k);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < 8; i++) begin
      if (k - i >= 0 && k - i < 8) r[i*16 +: 16] = d[(k-i)*16 +: 16];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: FIFO contents as a queue, frame position as an int.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last;
  bit           m_known;
  int           m_cnt;
  bit           m_fd;
  bit           m_push, m_pop;
  logic [W-1:0] out_log[$];
  int           dut_fd_cnt = 0;
  int           drv_pos = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_last  = '0;
      m_known = 1;
      m_cnt   = 0;
      m_fd    = 0;
    end else begin
      m_push = in_valid && mq.size() < 2;
      m_pop  = mq.size() > 0 && out_ready;
      if (nttend) begin
        mq.delete();
        m_cnt   = 0;
        m_fd    = 0;
        m_known = 0;
      end else begin
        m_fd = m_push && m_cnt == 127;
        if (m_pop) begin
          m_last  = mq.pop_front();
          m_known = 1;
        end
        if (m_push) begin
          mq.push_back(decom(lane_in, m_cnt / 8));
          m_cnt = (m_cnt + 1) % 128;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("out_valid", out_valid, mq.size() > 0);
      chk("in_ready", in_ready, mq.size() < 2);
      chk("group_idx", group_idx, m_cnt / 8);
      chk("frame_done", frame_done, m_fd);
      if (mq.size() > 0) chk("lane_out", lane_out, mq[0]);
      else if (m_known) chk("lane_out_hold", lane_out, m_last);
      if (out_valid && out_ready && !nttend) out_log.push_back(lane_out);
      if (frame_done) dut_fd_cnt++;
    end
  end

  task automatic cyc(input bit v, input logic [W-1:0] d, input bit r,
                     input bit nt, output bit acc);
    in_valid  = v;
    lane_in   = d;
    out_ready = r;
    nttend    = nt;
    acc = v && in_ready && !nt;
    @(posedge clk);
    #2;
  endtask

  // mode 0 nat/always, 1 round-trip/always, 2 nat/random, 3 random/random
  task automatic feed(input int n, input int mode);
    int b = 0;
    int guard = 0;
    bit acc, v, r;
    logic [W-1:0] d;
    while (b < n && guard < 20*n + 20) begin
      v = (mode >= 2) ? ($urandom % 4 != 0) : 1'b1;
      r = (mode >= 2) ? ($urandom % 3 != 0) : 1'b1;
      unique case (mode)
        1:       d = decom(nat(drv_pos), drv_pos / 8);
        3:       d = rnd();
        default: d = nat(drv_pos);
      endcase
      cyc(v, d, r, 1'b0, acc);
      if (acc) begin
        b++;
        drv_pos = (drv_pos + 1) % 128;
      end
      guard++;
    end
    if (b < n) chk("feed_timeout", b, n);
  endtask

  task automatic drain(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    int bad;
    logic [W-1:0] pat;

    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lane_out", lane_out, 0);
    chk("rst_group_idx", group_idx, 0);
    chk("rst_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // natural-order frame
    out_log.delete();
    dut_fd_cnt = 0;
    feed(128, 0);
    drain(3);
    chk("t1_count", out_log.size(), 128);
    if (out_log.size() == 128) begin
      chk("t1_g7_lane0", out_log[56][0 +: 16], 504);
      chk("t1_g7_lane7", out_log[56][112 +: 16], 56);
      chk("t1_g8_lane1", out_log[64][16 +: 16], 512);
      chk("t1_g8_lane0", out_log[64][0 +: 16], 64);
      chk("t1_g8_lane4", out_log[64][64 +: 16], 320);
      chk("t1_g0_lane5", out_log[3][80 +: 16], 323);
      chk("t1_g15_lane2", out_log[127][32 +: 16], 255);
      chk("t1_g14_ident", out_log[115], nat(115));
    end
    chk("t1_frame_done", dut_fd_cnt, 1);

    // round trip through the input commutator mapping
    out_log.delete();
    feed(128, 1);
    drain(3);
    chk("t2_count", out_log.size(), 128);
    bad = 0;
    for (int b = 0; b < out_log.size(); b++)
      if (out_log[b] !== nat(b)) bad++;
    chk("t2_roundtrip", bad, 0);

    // backpressure from beat 3
    out_log.delete();
    feed(3, 0);
    drain(1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, nat(drv_pos), 1'b0, 1'b0, acc);
      if (acc) drv_pos++;
    end
    chk("t3_accepted", drv_pos, 5);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_stable", lane_out, nat(3));
    feed(123, 2);
    drain(4);
    chk("t3_count", out_log.size(), 128);
    bad = 0;
    for (int b = 0; b < out_log.size(); b++)
      if (out_log[b] !== decom(nat(b), b / 8)) bad++;
    chk("t3_order", bad, 0);

    // push/pop at occ=1, then full-then-pop
    feed(20, 0);
    chk("t4_valid", out_valid, 1);
    cyc(1'b1, nat(drv_pos), 1'b0, 1'b0, acc);
    if (acc) drv_pos++;
    chk("t4_full", in_ready, 0);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    chk("t4_reopen", in_ready, 1);
    feed(40, 3);

    // nttend at beat 40 with two beats buffered
    cyc(1'b0, '0, 1'b1, 1'b1, acc);
    drv_pos = 0;
    drain(2);
    feed(39, 0);
    cyc(1'b1, nat(39), 1'b0, 1'b0, acc);
    if (acc) drv_pos++;
    chk("t5_full", in_ready, 0);
    cyc(1'b1, nat(40), 1'b0, 1'b1, acc);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_group_idx", group_idx, 0);
    out_log.delete();
    drv_pos = 0;
    pat = rnd();
    cyc(1'b1, pat, 1'b1, 1'b0, acc);
    drv_pos++;
    drain(3);
    chk("t5_count", out_log.size(), 1);
    if (out_log.size() > 0) chk("t5_identity", out_log[0], pat);

    // async reset at beat 70, then two full frames
    feed(69, 0);
    chk("t6_pre_idx", group_idx, 8);
    rst_n = 1'b0;
    #1;
    chk("t6_in_ready", in_ready, 1);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_lane_out", lane_out, 0);
    chk("t6_group_idx", group_idx, 0);
    chk("t6_frame_done", frame_done, 0);
    drv_pos = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    dut_fd_cnt = 0;
    feed(256, 3);
    drain(4);
    chk("t6_frame_done_cnt", dut_fd_cnt, 2);
    chk("t6_wrap_idx", group_idx, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
